program_sequencer: RTL and testbench

Sequences the accelerator's instruction stream. It fetches instruction words from program memory over a valid handshake and issues one opcode/operand pair per instruction to `instruction_decoder` and the ALU datapath. It stretches WAIT instructions for a counted number of cycles and holds LDSW until the switch-load source signals data ready. It sits between program memory and the decoder and is the only driver of the decoder's opcode input.

---
 rtl/cpu_ctrl_pkg.sv | 17 +
 rtl/opcodes.sv | 13 +
 rtl/program_sequencer_wait_counter.sv | 22 ++
 rtl/program_sequencer.sv | 128 ++++++++++++
 tb/tb_program_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer state enum and opcode constants shared by RTL, bench and debug probes.
`include "opcodes.sv"
package cpu_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LDWAIT,
        S_ISSUE,
        S_WAIT
    } seq_state_t;
    localparam logic [2:0] OP_MOV  = `OP_MOV;
    localparam logic [2:0] OP_SETB = `OP_SETB;
    localparam logic [2:0] OP_MAC  = `OP_MAC;
    localparam logic [2:0] OP_WAIT = `OP_WAIT;
    localparam logic [2:0] OP_LDSW = `OP_LDSW;
    localparam logic [2:0] OP_IDLE = `OP_IDLE;
endpackage

// File: rtl/opcodes.sv
// opcodes: shared instruction opcode encodings for the accelerator control path.
// IDLE is the encoding the decoder maps to its all-zero default.
`ifndef OPCODES_SV
`define OPCODES_SV
`define OP_MOV  3'b000
`define OP_SETB 3'b001
`define OP_MAC  3'b010
`define OP_WAIT 3'b011
`define OP_LDSW 3'b100
`define OP_ADD  3'b101
`define OP_CLR  3'b110
`define OP_IDLE 3'b111
`endif

// File: rtl/program_sequencer_wait_counter.sv
// wait_counter: load/decrement counter that stretches WAIT instructions.
// Ports: clk, rst (sync, active high); clr_i discards the count; load_i loads val_i;
// dec_i decrements (saturating at 0); expire_o is high while the count equals 1.
module wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             expire_o
);
    logic [WIDTH-1:0] count_q;
    assign expire_o = count_q == WIDTH'(1);
    always_ff @(posedge clk) begin
        if (rst || clr_i) count_q <= '0;
        else if (load_i) count_q <= val_i;
        else if (dec_i && count_q != '0) count_q <= count_q - WIDTH'(1);
    end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: fetches instructions over a valid handshake and issues opcode/operand to the decoder.
// Ports: clk, rst (sync, active high); start/abort run control; prog_last last address;
// imem_req/imem_addr/imem_rdata/imem_valid program memory fetch; ld_valid switch data ready;
// opcode/operand/issue registered decoder outputs; busy (not idle); done completion pulse.
module program_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH  = 3,
    parameter int OPERAND_WIDTH = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter logic [OPCODE_WIDTH-1:0] IDLE_OPCODE = OP_IDLE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDR_WIDTH-1:0]             prog_last,
    output logic                              imem_req,
    output logic [ADDR_WIDTH-1:0]             imem_addr,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_rdata,
    input  logic                              imem_valid,
    input  logic                              ld_valid,
    output logic [OPCODE_WIDTH-1:0]           opcode,
    output logic [OPERAND_WIDTH-1:0]          operand,
    output logic                              issue,
    output logic                              busy,
    output logic                              done
);
    seq_state_t                              state_q;
    logic [ADDR_WIDTH-1:0]                   pc_q, last_q;
    logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0]   ir_q;
    logic [OPCODE_WIDTH-1:0]                 opcode_q;
    logic [OPERAND_WIDTH-1:0]                operand_q;
    logic                                    req_q, issue_q, busy_q, done_q;
    logic [OPCODE_WIDTH-1:0]                 rd_op, ir_op;
    logic [OPERAND_WIDTH-1:0]                rd_arg, ir_arg;
    logic                                    wait_load, advance, expire;
    assign rd_op  = imem_rdata[OPCODE_WIDTH+OPERAND_WIDTH-1 -: OPCODE_WIDTH];
    assign rd_arg = imem_rdata[OPERAND_WIDTH-1:0];
    assign ir_op  = ir_q[OPCODE_WIDTH+OPERAND_WIDTH-1 -: OPCODE_WIDTH];
    assign ir_arg = ir_q[OPERAND_WIDTH-1:0];
    // In ISSUE opcode_q/operand_q hold the instruction being issued.
    assign wait_load = state_q == S_ISSUE && opcode_q == OP_WAIT && operand_q != '0;
    assign advance   = (state_q == S_ISSUE && !wait_load) || (state_q == S_WAIT && expire);
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign opcode    = opcode_q;
    assign operand   = operand_q;
    assign issue     = issue_q;
    assign busy      = busy_q;
    assign done      = done_q;
    wait_counter #(.WIDTH(OPERAND_WIDTH)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (abort),
        .load_i   (wait_load),
        .dec_i    (state_q == S_WAIT),
        .val_i    (operand_q),
        .expire_o (expire)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            last_q    <= '0;
            ir_q      <= '0;
            opcode_q  <= IDLE_OPCODE;
            operand_q <= '0;
            req_q     <= 1'b0;
            issue_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q  <= S_IDLE;
                req_q    <= 1'b0;
                busy_q   <= 1'b0;
                opcode_q <= IDLE_OPCODE;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        last_q  <= prog_last;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                    S_FETCH: if (imem_valid) begin
                        ir_q  <= imem_rdata;
                        req_q <= 1'b0;
                        if (rd_op == OP_LDSW) state_q <= S_LDWAIT;
                        else begin
                            state_q   <= S_ISSUE;
                            issue_q   <= 1'b1;
                            opcode_q  <= rd_op;
                            operand_q <= rd_arg;
                        end
                    end
                    S_LDWAIT: if (ld_valid) begin
                        state_q   <= S_ISSUE;
                        issue_q   <= 1'b1;
                        opcode_q  <= ir_op;
                        operand_q <= ir_arg;
                    end
                    S_ISSUE, S_WAIT: begin
                        // WAIT keeps opcode_q at the WAIT encoding until the counter expires.
                        if (wait_load) state_q <= S_WAIT;
                        else if (advance) begin
                            opcode_q <= IDLE_OPCODE;
                            if (pc_q == last_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                pc_q    <= pc_q + ADDR_WIDTH'(1);
                                state_q <= S_FETCH;
                                req_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed self-checking bench for program_sequencer.
module tb_program_sequencer;
    import cpu_ctrl_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  prog_last = '0;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [10:0] imem_rdata;
    logic        imem_valid;
    logic        ld_valid = 1'b0;
    logic [2:0]  opcode;
    logic [7:0]  operand;
    logic        issue, busy, done;
    logic [10:0] mem [64];
    logic        rand_lat = 1'b0;
    int          req_age = 0;
    int          lat_cur = 0;
    int          stab_err = 0;
    logic        hold_pending = 1'b0;
    logic [5:0]  hold_addr = '0;
    logic [10:0] log_q [$];
    int          ncmp = 0;
    int          nerr = 0;
    int          dcyc, wcnt, bad;

    program_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_last(prog_last),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .ld_valid(ld_valid), .opcode(opcode),
        .operand(operand), .issue(issue), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign imem_valid = imem_req && (!rand_lat || req_age >= lat_cur);

    always @(posedge clk) begin
        if (imem_req && imem_valid) begin
            req_age <= 0;
            lat_cur <= int'($urandom_range(0, 3));
        end else if (imem_req) req_age <= req_age + 1;
        else req_age <= 0;
    end

    always @(negedge clk) begin
        if (hold_pending && (imem_req !== 1'b1 || imem_addr !== hold_addr)) stab_err++;
        hold_pending = imem_req && !imem_valid;
        hold_addr = imem_addr;
        if (issue === 1'b1) log_q.push_back({opcode, operand});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 0);
        chk({tag, "_addr"}, 32'(imem_addr), 0);
        chk({tag, "_issue"}, 32'(issue), 0);
        chk({tag, "_opcode"}, 32'(opcode), 32'(OP_IDLE));
        chk({tag, "_operand"}, 32'(operand), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Starts a run from IDLE, returns the cycle done was seen (-1 on timeout)
    // and the number of cycles opcode showed the WAIT encoding.
    task automatic run_prog(input logic [5:0] last, input int maxc, output int dc, output int wc);
        dc = -1;
        wc = 0;
        log_q.delete();
        prog_last = last;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            if (done === 1'b1) begin
                dc = c;
                break;
            end
            if (opcode === OP_WAIT) wc++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {OP_MAC, 8'h00};
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        // Basic program; start held high while busy and prog_last changed must not matter.
        mem[0] = {OP_MOV, 8'd5};
        mem[1] = {OP_SETB, 8'd3};
        mem[2] = {OP_MAC, 8'd0};
        prog_last = 6'd2;
        start = 1'b1;
        tick();
        prog_last = 6'd40;
        chk("c1_busy", 32'(busy), 1);
        chk("c1_req", 32'(imem_req), 1);
        chk("c1_opcode", 32'(opcode), 32'(OP_IDLE));
        tick();
        chk("c2_issue", 32'(issue), 1);
        chk("c2_instr", {opcode, operand}, {OP_MOV, 8'd5});
        tick();
        chk("c3_issue", 32'(issue), 0);
        chk("c3_opcode", 32'(opcode), 32'(OP_IDLE));
        chk("c3_operand_hold", 32'(operand), 5);
        chk("c3_addr", 32'(imem_addr), 1);
        tick();
        chk("c4_issue", 32'(issue), 1);
        chk("c4_instr", {opcode, operand}, {OP_SETB, 8'd3});
        tick();
        start = 1'b0;
        tick();
        chk("c6_issue", 32'(issue), 1);
        chk("c6_instr", {opcode, operand}, {OP_MAC, 8'd0});
        tick();
        chk("c7_done", 32'(done), 1);
        chk("c7_busy", 32'(busy), 0);
        start = 1'b1;
        prog_last = 6'd2;
        tick();
        start = 1'b0;
        chk("c8_done", 32'(done), 0);
        chk("c8_restart_busy", 32'(busy), 1);
        chk("c8_restart_addr", 32'(imem_addr), 0);
        tick();
        chk("c9_issue", 32'(issue), 1);
        rst = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        tick();
        // WAIT 4 between MACs.
        mem[0] = {OP_MAC, 8'd1};
        mem[1] = {OP_WAIT, 8'd4};
        mem[2] = {OP_MAC, 8'd2};
        run_prog(6'd2, 50, dcyc, wcnt);
        chk("wait4_done_cyc", 32'(dcyc), 11);
        chk("wait4_hold", 32'(wcnt), 5);
        chk("wait4_nissue", 32'(log_q.size()), 3);
        if (log_q.size() == 3) chk("wait4_next", 32'(log_q[2]), {OP_MAC, 8'd2});
        tick();
        mem[1] = {OP_WAIT, 8'd0};
        run_prog(6'd2, 50, dcyc, wcnt);
        chk("wait0_done_cyc", 32'(dcyc), 7);
        chk("wait0_hold", 32'(wcnt), 1);
        tick();
        // LDSW with delayed ld_valid and stray pulses outside LDWAIT.
        mem[0] = {OP_LDSW, 8'd9};
        mem[1] = {OP_MAC, 8'd3};
        prog_last = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        bad = 0;
        for (int c = 2; c <= 7; c++) begin
            if (opcode !== OP_IDLE || issue !== 1'b0 || busy !== 1'b1) bad++;
            if (c == 7) ld_valid = 1'b1;
            tick();
        end
        chk("ldwait_idle", 32'(bad), 0);
        chk("ld_issue", 32'(issue), 1);
        chk("ld_instr", {opcode, operand}, {OP_LDSW, 8'd9});
        tick();
        chk("ld_next_addr", 32'(imem_addr), 1);
        tick();
        ld_valid = 1'b0;
        chk("ld_mac_instr", {opcode, operand}, {OP_MAC, 8'd3});
        tick();
        chk("ld_done", 32'(done), 1);
        tick();
        // Random-latency memory over the full 64-word space.
        for (int i = 0; i < 64; i++)
            mem[i] = {(i % 3 == 0) ? OP_MOV : (i % 3 == 1) ? OP_SETB : OP_MAC, 8'(i * 3 + 1)};
        rand_lat = 1'b1;
        stab_err = 0;
        run_prog(6'd63, 3000, dcyc, wcnt);
        rand_lat = 1'b0;
        chk("rand_done", 32'(dcyc > 0), 1);
        chk("rand_stable", 32'(stab_err), 0);
        chk("rand_count", 32'(log_q.size()), 64);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (i >= log_q.size() || log_q[i] !== mem[i]) bad++;
        chk("rand_order", 32'(bad), 0);
        tick();
        // Abort during WAIT, then restart.
        mem[0] = {OP_WAIT, 8'd10};
        prog_last = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abw_waiting", {31'd0, issue}, 0);
        chk("abw_opcode", 32'(opcode), 32'(OP_WAIT));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abw_busy", 32'(busy), 0);
        chk("abw_req", 32'(imem_req), 0);
        chk("abw_done", 32'(done), 0);
        chk("abw_opcode_idle", 32'(opcode), 32'(OP_IDLE));
        tick();
        chk("abw_done_late", 32'(done), 0);
        mem[0] = {OP_MOV, 8'h11};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abw_restart_addr", 32'(imem_addr), 0);
        tick();
        chk("abw_restart_instr", {opcode, operand}, {OP_MOV, 8'h11});
        tick();
        chk("abw_restart_done", 32'(done), 1);
        tick();
        // Abort during FETCH of the second instruction, then restart from PC 0.
        mem[0] = {OP_MAC, 8'd1};
        mem[1] = {OP_MAC, 8'd2};
        prog_last = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abf_addr", 32'(imem_addr), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abf_busy", 32'(busy), 0);
        chk("abf_req", 32'(imem_req), 0);
        chk("abf_issue", 32'(issue), 0);
        chk("abf_done", 32'(done), 0);
        tick();
        run_prog(6'd1, 50, dcyc, wcnt);
        chk("abf_restart_done", 32'(dcyc), 5);
        chk("abf_restart_count", 32'(log_q.size()), 2);
        if (log_q.size() == 2) chk("abf_restart_first", 32'(log_q[0]), {OP_MAC, 8'd1});
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
